// File: rtl/pp_pkg.sv
// Shared types and defaults for the memory port arbiter.
package pp_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_IF  = 2'd1,
        WAIT_MEM = 2'd2
    } arb_state_t;

    // Default read latency of the shared memory port (legal 1..7).
    localparam int MEM_LAT_DEF = 2;

    // Latency counter width; fits MEM_LAT-1 for every legal MEM_LAT.
    localparam int LAT_W = 3;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-port signal bundle for mem_port_arbiter.
// slave = arbiter view, master = requesters + memory model view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    // instruction fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    // load/store requester
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    // shared single-port memory
    logic              mport_en;
    logic              mport_we;
    logic [ADDR_W-1:0] mport_addr;
    logic [DATA_W-1:0] mport_wdata;
    logic [BE_W-1:0]   mport_be;
    logic [DATA_W-1:0] mport_rdata;

    logic              stall_if;
    logic              stall_mem;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata,
        output mport_en, mport_we, mport_addr, mport_wdata, mport_be,
        input  mport_rdata,
        output stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata,
        input  mport_en, mport_we, mport_addr, mport_wdata, mport_be,
        output mport_rdata,
        input  stall_if, stall_mem
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port memory with fixed read latency.
// MEM has priority; IF gets a forced turn after MAX_MEM_STREAK MEM grants
// it has waited through. One transaction in flight at a time.
module mem_port_arbiter
    import pp_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MEM_LAT        = MEM_LAT_DEF,
    parameter int MAX_MEM_STREAK = 4
) (
    input  logic               clk,
    input  logic               rstb,
    mem_port_arbiter_if.slave  bus
);

    localparam int BE_W   = DATA_W / 8;
    // +2 keeps the width non-zero even for MAX_MEM_STREAK = 0
    localparam int STRK_W = $clog2(MAX_MEM_STREAK + 2);

    arb_state_t        state, state_nxt;
    logic [LAT_W-1:0]  lat_cnt;
    logic [STRK_W-1:0] streak;
    logic              txn_we;

    logic              if_pick, mem_pick;
    logic              streak_full;
    logic              rsp;

    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [BE_W-1:0]   cmd_be;
    logic              cmd_we;

    assign streak_full = (streak == STRK_W'(MAX_MEM_STREAK));

    // Grant decision: only in IDLE, never while reset is asserted.
    always_comb begin
        if_pick  = 1'b0;
        mem_pick = 1'b0;
        if (state == IDLE && !rstb) begin
            if (bus.if_req && (!bus.mem_req || streak_full))
                if_pick = 1'b1;
            else if (bus.mem_req)
                mem_pick = 1'b1;
        end
    end

    // Response cycle: latency counter has run out in a WAIT state.
    assign rsp = (state != IDLE) && (lat_cnt == '0) && !rstb;

    // State register.
    always_ff @(posedge clk) begin
        if (rstb)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (if_pick)
                    state_nxt = WAIT_IF;
                else if (mem_pick)
                    state_nxt = WAIT_MEM;
            end
            WAIT_IF, WAIT_MEM: begin
                if (lat_cnt == '0)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latency counter: loaded on grant, counts down to the response cycle.
    always_ff @(posedge clk) begin
        if (rstb)
            lat_cnt <= '0;
        else if (if_pick || mem_pick)
            lat_cnt <= LAT_W'(MEM_LAT - 1);
        else if (lat_cnt != '0)
            lat_cnt <= lat_cnt - 1'b1;
    end

    // Remember whether the in-flight access is a store (ack with zero data).
    always_ff @(posedge clk) begin
        if (rstb)
            txn_we <= 1'b0;
        else if (mem_pick)
            txn_we <= bus.mem_we;
        else if (if_pick)
            txn_we <= 1'b0;
    end

    // Streak of MEM grants taken while IF was waiting; saturates.
    always_ff @(posedge clk) begin
        if (rstb || !bus.if_req || if_pick)
            streak <= '0;
        else if (mem_pick && !streak_full)
            streak <= streak + 1'b1;
    end

    // Command mux: fields come from whichever requester won this cycle.
    always_comb begin
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_be    = '0;
        cmd_we    = 1'b0;
        if (mem_pick) begin
            cmd_addr  = bus.mem_addr;
            cmd_wdata = bus.mem_wdata;
            cmd_be    = bus.mem_be;
            cmd_we    = bus.mem_we;
        end else if (if_pick) begin
            cmd_addr  = bus.if_addr;
        end
    end

    // Outputs: grants, memory command, owner-only response, stalls.
    always_comb begin
        bus.if_gnt      = if_pick;
        bus.mem_gnt     = mem_pick;
        bus.mport_en    = if_pick | mem_pick;
        bus.mport_we    = cmd_we;
        bus.mport_addr  = cmd_addr;
        bus.mport_wdata = cmd_wdata;
        bus.mport_be    = cmd_be;

        bus.if_rvalid   = rsp && (state == WAIT_IF);
        bus.mem_rvalid  = rsp && (state == WAIT_MEM);
        bus.if_rdata    = '0;
        bus.mem_rdata   = '0;
        if (bus.if_rvalid)
            bus.if_rdata = bus.mport_rdata;
        if (bus.mem_rvalid && !txn_we)
            bus.mem_rdata = bus.mport_rdata;

        bus.stall_if    = bus.if_req  & ~if_pick;
        bus.stall_mem   = bus.mem_req & ~mem_pick;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LAT=2, MAX_MEM_STREAK=4).
// Inputs change 1 time unit after the rising edge; outputs sampled 2 units later.
module tb_mem_port_arbiter;

    logic clk;
    logic rstb;
    int   n_chk = 0;
    int   n_err = 0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .MAX_MEM_STREAK(4)
    ) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_be    = '0;
    endtask

    initial begin
        rstb = 1'b1;
        idle_inputs();
        bus.mport_rdata = 32'hDEADBEEF;

        // reset: requests present, everything held at zero
        cyc(); cyc(); cyc();
        bus.if_req  = 1'b1;
        bus.mem_req = 1'b1;
        #2;
        chk("rst_if_gnt",     bus.if_gnt,     0);
        chk("rst_mem_gnt",    bus.mem_gnt,    0);
        chk("rst_mport_en",   bus.mport_en,   0);
        chk("rst_mport_addr", bus.mport_addr, 0);
        chk("rst_if_rvalid",  bus.if_rvalid,  0);
        chk("rst_mem_rvalid", bus.mem_rvalid, 0);
        chk("rst_if_rdata",   bus.if_rdata,   0);
        chk("rst_mem_rdata",  bus.mem_rdata,  0);
        chk("rst_stall_if",   bus.stall_if,   1);

        cyc();
        rstb = 1'b0;
        idle_inputs();
        #2;
        chk("idle_no_gnt", bus.mport_en, 0);

        // single fetch, response two cycles later
        cyc();
        bus.mport_rdata = 32'h8C080000;
        bus.if_req      = 1'b1;
        bus.if_addr     = 32'h00400000;
        #2;
        chk("f_if_gnt",     bus.if_gnt,     1);
        chk("f_mport_en",   bus.mport_en,   1);
        chk("f_mport_addr", bus.mport_addr, 32'h00400000);
        chk("f_mport_we",   bus.mport_we,   0);
        chk("f_mem_gnt",    bus.mem_gnt,    0);
        cyc();
        bus.if_req = 1'b0;
        #2;
        chk("f1_if_gnt",    bus.if_gnt,    0);
        chk("f1_mport_en",  bus.mport_en,  0);
        chk("f1_if_rvalid", bus.if_rvalid, 0);
        chk("f1_if_rdata",  bus.if_rdata,  0);
        // load arrives in the response cycle: must wait one cycle
        cyc();
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b0;
        bus.mem_addr = 32'h10000008;
        #2;
        chk("f2_if_rvalid",  bus.if_rvalid,  1);
        chk("f2_if_rdata",   bus.if_rdata,   32'h8C080000);
        chk("f2_mem_rvalid", bus.mem_rvalid, 0);
        chk("f2_mem_gnt",    bus.mem_gnt,    0);
        chk("f2_stall_mem",  bus.stall_mem,  1);
        cyc();
        #2;
        chk("f3_mem_gnt",    bus.mem_gnt,    1);
        chk("f3_mport_addr", bus.mport_addr, 32'h10000008);
        chk("f3_if_rvalid",  bus.if_rvalid,  0);
        cyc();
        bus.mem_req     = 1'b0;
        bus.mport_rdata = 32'h12345678;
        cyc();
        #2;
        chk("f5_mem_rvalid", bus.mem_rvalid, 1);
        chk("f5_mem_rdata",  bus.mem_rdata,  32'h12345678);
        chk("f5_if_rvalid",  bus.if_rvalid,  0);

        // simultaneous requests: MEM first, IF at T+3
        cyc();
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h00400004;
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b0;
        bus.mem_addr = 32'h10000000;
        #2;
        chk("p_mem_gnt",    bus.mem_gnt,    1);
        chk("p_if_gnt",     bus.if_gnt,     0);
        chk("p_stall_if",   bus.stall_if,   1);
        chk("p_mport_addr", bus.mport_addr, 32'h10000000);
        cyc();
        bus.mem_req = 1'b0;
        #2;
        chk("p1_if_gnt", bus.if_gnt, 0);
        cyc();
        #2;
        chk("p2_mem_rvalid", bus.mem_rvalid, 1);
        chk("p2_if_gnt",     bus.if_gnt,     0);
        cyc();
        #2;
        chk("p3_if_gnt",     bus.if_gnt,     1);
        chk("p3_mport_addr", bus.mport_addr, 32'h00400004);
        cyc();
        bus.if_req = 1'b0;
        cyc();
        #2;
        chk("p5_if_rvalid", bus.if_rvalid, 1);
        chk("p5_if_rdata",  bus.if_rdata,  32'h12345678);
        cyc();

        // starvation guard: 4 MEM grants then IF at T+12
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h00400008;
        bus.mem_req  = 1'b1;
        bus.mem_addr = 32'h10000010;
        for (int k = 0; k < 13; k++) begin
            #2;
            chk($sformatf("s%0d_mem_gnt", k), bus.mem_gnt, ((k % 3 == 0) && (k < 12)) ? 1 : 0);
            chk($sformatf("s%0d_if_gnt", k),  bus.if_gnt,  (k == 12) ? 1 : 0);
            cyc();
        end
        idle_inputs();
        #2;
        chk("s13_if_rvalid", bus.if_rvalid, 0);
        cyc();
        #2;
        chk("s14_if_rvalid",  bus.if_rvalid,  1);
        chk("s14_mem_rvalid", bus.mem_rvalid, 0);
        cyc();

        // store: write command at T, zero-data ack at T+2
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = 32'h10000004;
        bus.mem_wdata = 32'h0000002A;
        bus.mem_be    = 4'hF;
        #2;
        chk("w_mem_gnt",     bus.mem_gnt,     1);
        chk("w_mport_we",    bus.mport_we,    1);
        chk("w_mport_wdata", bus.mport_wdata, 32'h0000002A);
        chk("w_mport_be",    bus.mport_be,    4'hF);
        chk("w_mport_addr",  bus.mport_addr,  32'h10000004);
        cyc();
        idle_inputs();
        cyc();
        #2;
        chk("w2_mem_rvalid", bus.mem_rvalid, 1);
        chk("w2_mem_rdata",  bus.mem_rdata,  0);
        cyc();

        // reset mid-read: no response, new fetch granted right after reset
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h00400010;
        #2;
        chk("r_if_gnt", bus.if_gnt, 1);
        cyc();
        rstb = 1'b1;
        #2;
        chk("r1_if_gnt",    bus.if_gnt,    0);
        chk("r1_mport_en",  bus.mport_en,  0);
        chk("r1_if_rvalid", bus.if_rvalid, 0);
        cyc();
        rstb = 1'b0;
        #2;
        chk("r2_if_rvalid",  bus.if_rvalid,  0);
        chk("r2_if_rdata",   bus.if_rdata,   0);
        chk("r2_mem_rvalid", bus.mem_rvalid, 0);
        chk("r2_if_gnt",     bus.if_gnt,     1);
        cyc();
        bus.if_req = 1'b0;
        cyc();
        #2;
        chk("r4_if_rvalid", bus.if_rvalid, 1);
        chk("r4_if_rdata",  bus.if_rdata,  32'h12345678);
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
